// File: rtl/uart_fifo_ctrl.sv
// Host-side UART controller: TX FIFO feeding the UART transmit handshake,
// RX FIFO capturing received bytes, and a four-register byte-wide bus.
module uart_fifo_ctrl #(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] bus_addr,
  input  logic       bus_we,
  input  logic       bus_re,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       irq,
  output logic       TX_start,
  output logic [7:0] TX_data,
  input  logic       TX_done,
  input  logic [7:0] RX_data,
  input  logic       RX_dv
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_AW + 1;
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } tx_state_t;

  tx_state_t state, state_nxt;

  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_CW-1:0] tx_count;
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_CW-1:0] rx_count;

  logic       tx_drop, rx_overrun;
  logic [2:0] ien;

  logic       tx_full_c, tx_empty_c, rx_full_c, rx_empty_c;
  logic       wr_c, rd_c;
  logic       tx_push_c, tx_pop_c, tx_drop_set_c, tx_busy_c;
  logic       rx_push_c, rx_pop_c, rx_ovr_set_c;
  logic [7:0] status_c, rdata_nxt_c;
  logic       irq_nxt_c;

  // Bus decode: a write wins over a simultaneous read
  always_comb begin
    tx_full_c     = (tx_count == TX_CW'(TX_DEPTH));
    tx_empty_c    = (tx_count == '0);
    rx_full_c     = (rx_count == RX_CW'(RX_DEPTH));
    rx_empty_c    = (rx_count == '0);
    wr_c          = bus_we;
    rd_c          = bus_re && !bus_we;
    tx_push_c     = wr_c && (bus_addr == 2'd0) && (!tx_full_c || tx_pop_c);
    tx_drop_set_c = wr_c && (bus_addr == 2'd0) && tx_full_c && !tx_pop_c;
    rx_pop_c      = rd_c && (bus_addr == 2'd0) && !rx_empty_c;
    rx_push_c     = RX_dv && (!rx_full_c || rx_pop_c);
    rx_ovr_set_c  = RX_dv && rx_full_c && !rx_pop_c;
  end

  // TX FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // TX FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!tx_empty_c) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (TX_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // TX FSM: outputs; the head byte is popped on the IDLE->START transition
  always_comb begin
    tx_pop_c  = (state == S_IDLE) && !tx_empty_c;
    tx_busy_c = (state != S_IDLE);
  end

  // TX_start is registered so it is high exactly while the FSM sits in START
  always_ff @(posedge clock) begin
    if (reset) begin
      TX_start <= 1'b0;
      TX_data  <= 8'h00;
    end else begin
      TX_start <= tx_pop_c;
      if (tx_pop_c) TX_data <= tx_mem[tx_rd_ptr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push_c) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop_c)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      case ({tx_push_c, tx_pop_c})
        2'b10:   tx_count <= tx_count + TX_CW'(1);
        2'b01:   tx_count <= tx_count - TX_CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (tx_push_c) tx_mem[tx_wr_ptr] <= bus_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push_c) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop_c)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      case ({rx_push_c, rx_pop_c})
        2'b10:   rx_count <= rx_count + RX_CW'(1);
        2'b01:   rx_count <= rx_count - RX_CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (rx_push_c) rx_mem[rx_wr_ptr] <= RX_data;
  end

  // Sticky error bits (a new event wins over a same-cycle clear) and IEN
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_drop    <= 1'b0;
      rx_overrun <= 1'b0;
      ien        <= 3'b000;
    end else begin
      if (tx_drop_set_c)                                    tx_drop <= 1'b1;
      else if (wr_c && (bus_addr == 2'd1) && bus_wdata[6])  tx_drop <= 1'b0;
      if (rx_ovr_set_c)                                     rx_overrun <= 1'b1;
      else if (wr_c && (bus_addr == 2'd1) && bus_wdata[4])  rx_overrun <= 1'b0;
      if (wr_c && (bus_addr == 2'd2)) ien <= bus_wdata[2:0];
    end
  end

  // Read mux and interrupt, both registered below
  always_comb begin
    status_c    = {1'b0, tx_drop, tx_busy_c, rx_overrun, rx_full_c,
                   !rx_empty_c, tx_empty_c, tx_full_c};
    rdata_nxt_c = 8'h00;
    if (rd_c) begin
      case (bus_addr)
        2'd0:    if (!rx_empty_c) rdata_nxt_c = rx_mem[rx_rd_ptr];
        2'd1:    rdata_nxt_c = status_c;
        2'd2:    rdata_nxt_c = {5'b00000, ien};
        default: rdata_nxt_c = 8'(rx_count);
      endcase
    end
    irq_nxt_c = (ien[0] && !rx_empty_c)
              || (ien[1] && tx_empty_c && (state == S_IDLE))
              || (ien[2] && (rx_overrun || tx_drop));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus_rdata <= 8'h00;
      irq       <= 1'b0;
    end else begin
      bus_rdata <= rdata_nxt_c;
      irq       <= irq_nxt_c;
    end
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl: register-access vector table plus
// hand-written TX, RX, interrupt and reset sequences.
module tb_uart_fifo_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] bus_addr;
  logic       bus_we, bus_re;
  logic [7:0] bus_wdata, bus_rdata;
  logic       irq, TX_start, TX_done, RX_dv;
  logic [7:0] TX_data, RX_data;

  uart_fifo_ctrl #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clock(clock), .reset(reset), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_re(bus_re), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq(irq),
    .TX_start(TX_start), .TX_data(TX_data), .TX_done(TX_done),
    .RX_data(RX_data), .RX_dv(RX_dv)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // UART model: answers each TX_start with a TX_done pulse when enabled
  logic auto_done = 1'b0;
  initial begin
    TX_done = 1'b0;
    forever begin
      @(negedge clock);
      if (auto_done && TX_start) begin
        repeat (10) @(posedge clock);
        #1 TX_done = 1'b1;
        @(posedge clock);
        #1 TX_done = 1'b0;
      end
    end
  end

  // Transmit monitor: logs starts/dones and flags TX_data changes in flight
  int         starts = 0;
  int         stab_err = 0;
  logic       in_flight = 1'b0;
  logic [7:0] held;
  logic [7:0] start_data [64];
  int         start_cyc [64];
  int         done_cyc [64];
  always @(negedge clock) begin
    if (reset) in_flight = 1'b0;
    else begin
      if (in_flight && TX_done) begin
        in_flight = 1'b0;
        if (starts > 0 && starts <= 64) done_cyc[starts-1] = cyc;
      end
      if (TX_start) begin
        if (starts < 64) begin
          start_data[starts] = TX_data;
          start_cyc[starts]  = cyc;
        end
        starts++;
        held      = TX_data;
        in_flight = 1'b1;
      end else if (in_flight && TX_data !== held) stab_err++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(posedge clock);
    #1 bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    bus_re = 1'b1; bus_addr = a;
    @(posedge clock);
    #1 bus_re = 1'b0;
    d = bus_rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic       we;
    logic       re;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_irq;
  } vec_t;

  vec_t       vecs [13];
  logic [7:0] rd;
  int         base, push_cyc;

  initial begin
    reset = 1'b0; bus_addr = 2'd0; bus_we = 1'b0; bus_re = 1'b0;
    bus_wdata = 8'h00; RX_data = 8'h00; RX_dv = 1'b0;

    vecs[0]  = '{1'b0, 1'b1, 2'd1, 8'h00, 8'h02, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 8'hFF, 8'h00, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 2'd2, 8'h00, 8'h07, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 2'd3, 8'hAA, 8'h00, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 2'd2, 8'h00, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 2'd1, 8'h00, 8'h02, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 2'd2, 8'h02, 8'h00, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 2'd2, 8'h01, 8'h00, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 2'd2, 8'h04, 8'h00, 1'b0};

    do_reset();
    check("reset_rdata", 32'(bus_rdata), 32'h00);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_tx_start", 32'(TX_start), 32'h0);
    check("reset_tx_data", 32'(TX_data), 32'h00);

    // Register access table: data cycle, then an idle cycle for rdata=0 and irq
    for (int i = 0; i < 13; i++) begin
      bus_we = vecs[i].we; bus_re = vecs[i].re;
      bus_addr = vecs[i].addr; bus_wdata = vecs[i].wdata;
      @(posedge clock);
      #1 bus_we = 1'b0; bus_re = 1'b0;
      check($sformatf("vec%0d_rdata", i), 32'(bus_rdata), 32'(vecs[i].exp_rdata));
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_rdata_idle", i), 32'(bus_rdata), 32'h00);
      check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
      check($sformatf("vec%0d_tx_start", i), 32'(TX_start), 32'h0);
    end
    bus_write(2'd2, 8'h00);

    // Two-byte transmit with the UART model answering
    auto_done = 1'b1;
    base = starts;
    bus_write(2'd0, 8'h55);
    push_cyc = cyc;
    bus_write(2'd0, 8'hA3);
    for (int k = 0; k < 100 && !(starts == base + 2 && !in_flight); k++) @(posedge clock);
    idle(3);
    check("tx2_starts", 32'(starts - base), 32'd2);
    check("tx2_data0", 32'(start_data[base]), 32'h55);
    check("tx2_data1", 32'(start_data[base+1]), 32'hA3);
    check("tx2_first_latency", 32'(start_cyc[base] - push_cyc), 32'd1);
    check("tx2_done_to_start", 32'(start_cyc[base+1] - done_cyc[base]), 32'd2);
    check("tx2_data_stable", 32'(stab_err), 32'd0);
    bus_read(2'd1, rd);
    check("tx2_status_idle", 32'(rd), 32'h02);
    auto_done = 1'b0;

    // TX overflow: one byte in flight plus sixteen queued, then a drop
    do_reset();
    base = starts;
    for (int i = 0; i < 17; i++) bus_write(2'd0, 8'(8'h10 + i));
    idle(1);
    check("ovf_starts", 32'(starts - base), 32'd1);
    check("ovf_tx_data", 32'(TX_data), 32'h10);
    bus_read(2'd1, rd);
    check("ovf_status_full", 32'(rd), 32'h21);
    bus_write(2'd0, 8'h77);
    bus_read(2'd1, rd);
    check("ovf_status_drop", 32'(rd), 32'h61);
    bus_write(2'd1, 8'h40);
    bus_read(2'd1, rd);
    check("ovf_drop_cleared", 32'(rd), 32'h21);
    // Finish the in-flight byte and push on the very edge the FSM pops
    TX_done = 1'b1;
    @(posedge clock);
    #1 TX_done = 1'b0;
    bus_write(2'd0, 8'h88);
    idle(1);
    bus_read(2'd1, rd);
    check("full_pop_push_status", 32'(rd), 32'h21);
    check("full_pop_push_data", 32'(TX_data), 32'h11);

    // Reset in WAIT with three bytes queued
    do_reset();
    for (int i = 0; i < 4; i++) bus_write(2'd0, 8'(8'h31 + i));
    idle(5);
    bus_read(2'd1, rd);
    check("rst_pre_status", 32'(rd), 32'h20);
    check("rst_pre_data", 32'(TX_data), 32'h31);
    do_reset();
    check("rst_tx_data", 32'(TX_data), 32'h00);
    base = starts;
    idle(30);
    check("rst_no_start", 32'(starts - base), 32'd0);
    bus_read(2'd1, rd);
    check("rst_status", 32'(rd), 32'h02);
    auto_done = 1'b1;
    bus_write(2'd0, 8'h99);
    for (int k = 0; k < 20 && starts == base; k++) @(posedge clock);
    #1;
    check("rst_new_start", 32'(starts - base), 32'd1);
    check("rst_new_data", 32'(start_data[base]), 32'h99);
    for (int k = 0; k < 40 && in_flight; k++) @(posedge clock);
    idle(3);
    auto_done = 1'b0;

    // RX overrun, full-FIFO push+pop, drain, empty read
    do_reset();
    for (int i = 0; i < 17; i++) begin
      RX_data = 8'(i); RX_dv = 1'b1;
      @(posedge clock);
      #1;
    end
    RX_dv = 1'b0;
    bus_read(2'd3, rd);
    check("rx_count_full", 32'(rd), 32'd16);
    bus_read(2'd1, rd);
    check("rx_status_full", 32'(rd), 32'h1E);
    RX_data = 8'h20; RX_dv = 1'b1;
    bus_read(2'd0, rd);
    RX_dv = 1'b0;
    check("rx_pushpop_data", 32'(rd), 32'h00);
    bus_read(2'd3, rd);
    check("rx_pushpop_count", 32'(rd), 32'd16);
    for (int i = 1; i < 16; i++) begin
      bus_read(2'd0, rd);
      check($sformatf("rx_drain%0d", i), 32'(rd), 32'(i));
    end
    bus_read(2'd0, rd);
    check("rx_drain_last", 32'(rd), 32'h20);
    bus_read(2'd0, rd);
    check("rx_empty_read", 32'(rd), 32'h00);
    bus_read(2'd1, rd);
    check("rx_status_empty", 32'(rd), 32'h12);
    bus_write(2'd1, 8'h10);
    bus_read(2'd1, rd);
    check("rx_ovr_cleared", 32'(rd), 32'h02);

    // rx_avail interrupt
    bus_write(2'd2, 8'h01);
    RX_data = 8'h7E; RX_dv = 1'b1;
    @(posedge clock);
    #1 RX_dv = 1'b0;
    check("irq_not_yet", 32'(irq), 32'h0);
    idle(1);
    check("irq_rise", 32'(irq), 32'h1);
    bus_read(2'd0, rd);
    check("irq_read_data", 32'(rd), 32'h7E);
    check("irq_hold", 32'(irq), 32'h1);
    idle(1);
    check("irq_fall", 32'(irq), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
